// File: rtl/alu_share_arb.sv
// Shares one combinational ALU between a main (port 0) and an auxiliary (port 1) requester.
// Optional ALU_ARB_FIXED_PRIO_EN: port 0 wins ties, with a MAX_WAIT starvation guard for port 1.
module alu_share_rsp #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cap,
  input  logic             clr,
  input  logic [WIDTH-1:0] c_in,
  input  logic             zero_in,
  output logic             valid,
  output logic [WIDTH-1:0] c,
  output logic             zero
);
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      c     <= '0;
      zero  <= 1'b0;
    end else if (cap) begin
      valid <= 1'b1;
      c     <= c_in;
      zero  <= zero_in;
    end else if (clr) begin
      valid <= 1'b0;
    end
  end
endmodule

module alu_share_arb #(
  parameter int          WIDTH    = 32,
  parameter int          OPW      = 4,
  parameter int unsigned NOP_OP   = 0,
  parameter int          MAX_WAIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [OPW-1:0]   req0_op,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [WIDTH-1:0] rsp0_c,
  output logic             rsp0_zero,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [OPW-1:0]   req1_op,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp1_c,
  output logic             rsp1_zero,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OPW-1:0]   alu_op,
  input  logic [WIDTH-1:0] alu_c,
  input  logic             alu_zero
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t state, state_nxt;
  logic   gnt, sel, tie, hs, rsp_rdy, done;
  logic [1:0]            rsp_vld, rsp_zero;
  logic [1:0][WIDTH-1:0] rsp_c;

`ifdef ALU_ARB_FIXED_PRIO_EN
  localparam int CW = $clog2(MAX_WAIT + 1);
  logic [CW-1:0] wait_cnt;

  // port 1 only wins a tie once it has been passed over MAX_WAIT idle cycles
  assign tie = (wait_cnt >= CW'(MAX_WAIT));

  always_ff @(posedge clk) begin
    if (rst)                                                wait_cnt <= '0;
    else if (hs && sel)                                     wait_cnt <= '0;
    else if (state == IDLE && req1_valid && wait_cnt < CW'(MAX_WAIT))
                                                            wait_cnt <= wait_cnt + 1'b1;
  end
`else
  logic last;

  assign tie = ~last;

  always_ff @(posedge clk) begin
    if (rst)     last <= 1'b1;
    else if (hs) last <= sel;
  end
`endif

  always_comb begin
    sel = req1_valid;
    if (req0_valid && req1_valid) sel = tie;
  end

  assign hs         = (state == IDLE) && (req0_valid || req1_valid);
  assign req0_ready = hs && !sel;
  assign req1_ready = hs && sel;
  assign rsp_rdy    = gnt ? rsp1_ready : rsp0_ready;
  assign done       = (state == RESP) && rsp_rdy;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (hs)      state_nxt = EXEC;
      EXEC:                 state_nxt = RESP;
      RESP:    if (rsp_rdy) state_nxt = IDLE;
      default:              state_nxt = IDLE;
    endcase
  end

  // operands are parked at zero / NOP whenever nothing is in flight
  always_ff @(posedge clk) begin
    if (rst || done) begin
      alu_a  <= '0;
      alu_b  <= '0;
      alu_op <= OPW'(NOP_OP);
      if (rst) gnt <= 1'b0;
    end else if (hs) begin
      alu_a  <= sel ? req1_a  : req0_a;
      alu_b  <= sel ? req1_b  : req0_b;
      alu_op <= sel ? req1_op : req0_op;
      gnt    <= sel;
    end
  end

  for (genvar i = 0; i < 2; i++) begin : g_rsp
    alu_share_rsp #(.WIDTH(WIDTH)) u_rsp (
      .clk     (clk),
      .rst     (rst),
      .cap     ((state == EXEC) && (gnt == 1'(i))),
      .clr     (done && (gnt == 1'(i))),
      .c_in    (alu_c),
      .zero_in (alu_zero),
      .valid   (rsp_vld[i]),
      .c       (rsp_c[i]),
      .zero    (rsp_zero[i])
    );
  end

  assign rsp0_valid = rsp_vld[0];
  assign rsp1_valid = rsp_vld[1];
  assign rsp0_c     = rsp_c[0];
  assign rsp1_c     = rsp_c[1];
  assign rsp0_zero  = rsp_zero[0];
  assign rsp1_zero  = rsp_zero[1];
endmodule
